// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Bundles the control/datapath signals of the multicycle MIPS controller.
//   master : the controller (reads op/funct/zero, drives selects, enables, state)
//   slave  : the datapath (drives op/funct/zero, consumes the controls)
//   This is a cycle-level control bundle: there is no flow control. The
//   controller acts on op/funct/zero every cycle, and the datapath acts on
//   the selects and enables in the same cycle they are driven.
interface multicycle_control_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic [2:0] aluControl;
   logic       aluSrcA;
   logic [1:0] aluSrcB;
   logic [1:0] pcSrc;
   logic       iorD;
   logic       irWrite;
   logic       memWrite;
   logic       regWrite;
   logic       regDst;
   logic       memtoReg;
   logic       pcEn;
   logic       instrDone;
   logic       illegalOp;
   logic [3:0] state;

   modport master (
      input  op, funct, zero,
      output aluControl, aluSrcA, aluSrcB, pcSrc, iorD, irWrite, memWrite,
             regWrite, regDst, memtoReg, pcEn, instrDone, illegalOp, state
   );

   modport slave (
      output op, funct, zero,
      input  aluControl, aluSrcA, aluSrcB, pcSrc, iorD, irWrite, memWrite,
             regWrite, regDst, memtoReg, pcEn, instrDone, illegalOp, state
   );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore main controller plus ALU decoder for the multicycle MIPS datapath.
//   Ports:
//     clk    : system clock, rising edge
//     resetN : asynchronous active-low reset
//     dp     : multicycle_control_if.master (op/funct/zero in; selects,
//              enables, aluControl, instrDone, illegalOp, debug state out)
module multicycle_control (
   input logic                  clk,
   input logic                  resetN,
   multicycle_control_if.master dp
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   state_t     state_q;
   logic       op_legal;
   logic       funct_legal;
   logic       illegal;

   logic [1:0] alu_op;
   logic       pc_write;
   logic       branch;
   logic       ir_write_d;
   logic       mem_write_d;
   logic       reg_write_d;
   logic       done_d;
   logic       illegal_d;

   assign op_legal    = (dp.op == OP_RTYPE) || (dp.op == OP_LW) || (dp.op == OP_SW) ||
                        (dp.op == OP_BEQ) || (dp.op == OP_ADDI) || (dp.op == OP_J);
   assign funct_legal = (dp.funct == FN_ADD) || (dp.funct == FN_SUB) || (dp.funct == FN_AND) ||
                        (dp.funct == FN_OR) || (dp.funct == FN_SLT);
   assign illegal     = !op_legal || ((dp.op == OP_RTYPE) && !funct_legal);

   // Sequencer. Unused encodings 12-15 fall back to FETCH via default.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= S_FETCH;
      end else begin
         case (state_q)
            S_FETCH:  state_q <= S_DECODE;
            S_DECODE: begin
               if (illegal) begin
                  state_q <= S_FETCH;
               end else begin
                  case (dp.op)
                     OP_LW, OP_SW: state_q <= S_MEMADR;
                     OP_RTYPE:     state_q <= S_EXECUTE;
                     OP_BEQ:       state_q <= S_BRANCH;
                     OP_ADDI:      state_q <= S_ADDIEXEC;
                     OP_J:         state_q <= S_JUMP;
                     default:      state_q <= S_FETCH;
                  endcase
               end
            end
            S_MEMADR:   state_q <= (dp.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_q <= S_MEMWB;
            S_EXECUTE:  state_q <= S_ALUWB;
            S_ADDIEXEC: state_q <= S_ADDIWB;
            default:    state_q <= S_FETCH;
         endcase
      end
   end

   // Moore decode of the current state; DECODE additionally looks at op/funct.
   always_comb begin
      alu_op        = 2'b00;
      pc_write      = 1'b0;
      branch        = 1'b0;
      ir_write_d    = 1'b0;
      mem_write_d   = 1'b0;
      reg_write_d   = 1'b0;
      done_d        = 1'b0;
      illegal_d     = 1'b0;
      dp.aluSrcA    = 1'b0;
      dp.aluSrcB    = 2'b00;
      dp.pcSrc      = 2'b00;
      dp.iorD       = 1'b0;
      dp.regDst     = 1'b0;
      dp.memtoReg   = 1'b0;
      case (state_q)
         S_FETCH: begin
            dp.aluSrcB = 2'b01;
            ir_write_d = 1'b1;
            pc_write   = 1'b1;
         end
         S_DECODE: begin
            dp.aluSrcB = 2'b11;
            illegal_d  = illegal;
            done_d     = illegal;
         end
         S_MEMADR: begin
            dp.aluSrcA = 1'b1;
            dp.aluSrcB = 2'b10;
         end
         S_MEMRD: dp.iorD = 1'b1;
         S_MEMWB: begin
            dp.memtoReg = 1'b1;
            reg_write_d = 1'b1;
            done_d      = 1'b1;
         end
         S_MEMWR: begin
            dp.iorD     = 1'b1;
            mem_write_d = 1'b1;
            done_d      = 1'b1;
         end
         S_EXECUTE: begin
            dp.aluSrcA = 1'b1;
            alu_op     = 2'b10;
         end
         S_ALUWB: begin
            dp.regDst   = 1'b1;
            reg_write_d = 1'b1;
            done_d      = 1'b1;
         end
         S_BRANCH: begin
            dp.aluSrcA = 1'b1;
            alu_op     = 2'b01;
            dp.pcSrc   = 2'b01;
            branch     = 1'b1;
            done_d     = 1'b1;
         end
         S_ADDIEXEC: begin
            dp.aluSrcA = 1'b1;
            dp.aluSrcB = 2'b10;
         end
         S_ADDIWB: begin
            reg_write_d = 1'b1;
            done_d      = 1'b1;
         end
         S_JUMP: begin
            dp.pcSrc = 2'b10;
            pc_write = 1'b1;
            done_d   = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU decoder.
   always_comb begin
      dp.aluControl = 3'b010;
      case (alu_op)
         2'b01: dp.aluControl = 3'b110;
         2'b10: begin
            case (dp.funct)
               FN_SUB:  dp.aluControl = 3'b110;
               FN_AND:  dp.aluControl = 3'b000;
               FN_OR:   dp.aluControl = 3'b001;
               FN_SLT:  dp.aluControl = 3'b111;
               default: dp.aluControl = 3'b010;
            endcase
         end
         default: dp.aluControl = 3'b010;
      endcase
   end

   // Reset already forces FETCH, whose decode asserts irWrite/pcWrite; the
   // enables are gated with resetN so nothing is written while reset is held.
   assign dp.irWrite   = resetN & ir_write_d;
   assign dp.memWrite  = resetN & mem_write_d;
   assign dp.regWrite  = resetN & reg_write_d;
   assign dp.pcEn      = resetN & (pc_write | (branch & dp.zero));
   assign dp.instrDone = resetN & done_d;
   assign dp.illegalOp = resetN & illegal_d;
   assign dp.state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Self-checking bench for multicycle_control. A reference model turns each
//   instruction into its expected state walk and per-cycle control vector,
//   queued in exp_q; scenario tasks pop and compare at the falling edge.
module tb_multicycle_control;

   logic clk;
   logic resetN;
   int   checks;
   int   errors;

   logic [20:0] exp_q[$];
   logic [20:0] obs;
   logic [20:0] exp_v;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk    (clk),
      .resetN (resetN),
      .dp     (bus)
   );

   // Observed vector: state, aluControl, aluSrcA, aluSrcB, pcSrc, iorD,
   // irWrite, memWrite, regWrite, regDst, memtoReg, pcEn, instrDone, illegalOp.
   assign obs = {bus.state, bus.aluControl, bus.aluSrcA, bus.aluSrcB, bus.pcSrc,
                 bus.iorD, bus.irWrite, bus.memWrite, bus.regWrite, bus.regDst,
                 bus.memtoReg, bus.pcEn, bus.instrDone, bus.illegalOp};

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [20:0] pack(input logic [3:0] st, input logic [2:0] alu,
                                        input logic sa, input logic [1:0] sb,
                                        input logic [1:0] ps, input logic iord,
                                        input logic irw, input logic memw,
                                        input logic regw, input logic rdst,
                                        input logic m2r, input logic pcen,
                                        input logic done, input logic ill);
      return {st, alu, sa, sb, ps, iord, irw, memw, regw, rdst, m2r, pcen, done, ill};
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] funct);
      case (funct)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Expected controls for one step of an instruction, from the state table.
   function automatic logic [20:0] model_vec(input int st, input logic [5:0] funct,
                                             input logic zero, input logic ill_instr);
      logic [2:0] alu = 3'b010;
      logic sa = 0, iord = 0, irw = 0, memw = 0, regw = 0, rdst = 0, m2r = 0;
      logic pcen = 0, done = 0, ill = 0;
      logic [1:0] sb = 2'b00, ps = 2'b00;
      case (st)
         0:  begin sb = 2'b01; irw = 1; pcen = 1; end
         1:  begin sb = 2'b11; ill = ill_instr; done = ill_instr; end
         2:  begin sa = 1; sb = 2'b10; end
         3:  iord = 1;
         4:  begin m2r = 1; regw = 1; done = 1; end
         5:  begin iord = 1; memw = 1; done = 1; end
         6:  begin sa = 1; alu = funct_alu(funct); end
         7:  begin rdst = 1; regw = 1; done = 1; end
         8:  begin sa = 1; alu = 3'b110; ps = 2'b01; pcen = zero; done = 1; end
         9:  begin sa = 1; sb = 2'b10; end
         10: begin regw = 1; done = 1; end
         11: begin ps = 2'b10; pcen = 1; done = 1; end
         default: ;
      endcase
      return pack(st[3:0], alu, sa, sb, ps, iord, irw, memw, regw, rdst, m2r, pcen, done, ill);
   endfunction

   function automatic logic [20:0] reset_vec();
      return pack(4'd0, 3'b010, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   // ---------------- driver ----------------
   // Drives one instruction's op/funct/zero and queues its expected walk.
   task automatic drive_instr(input logic [5:0] op, input logic [5:0] funct, input logic zero);
      int  seq[$];
      bit  legal_fn;
      legal_fn = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100) ||
                 (funct == 6'b100101) || (funct == 6'b101010);
      case (op)
         6'b100011: seq = '{0, 1, 2, 3, 4};
         6'b101011: seq = '{0, 1, 2, 5};
         6'b000000: if (legal_fn) seq = '{0, 1, 6, 7}; else seq = '{0, 1};
         6'b000100: seq = '{0, 1, 8};
         6'b001000: seq = '{0, 1, 9, 10};
         6'b000010: seq = '{0, 1, 11};
         default:   seq = '{0, 1};
      endcase
      bus.op    = op;
      bus.funct = funct;
      bus.zero  = zero;
      foreach (seq[i]) exp_q.push_back(model_vec(seq[i], funct, zero, seq.size() == 2));
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      resetN    = 1'b0;
      bus.op    = 6'b100011;
      bus.funct = 6'b000000;
      bus.zero  = 1'b0;
      #2;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== reset_vec()) begin
            errors++;
            $display("FAIL reset[%0d]: got %h expected %h", i, obs, reset_vec());
         end
      end
      @(posedge clk);
      #1 resetN = 1'b1;
      drive_instr(6'b100011, $urandom_range(0, 63), $urandom_range(0, 1));
      for (int n = exp_q.size(), i = 0; i < n; i++) begin
         @(negedge clk);
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL lw step %0d: got %h expected %h", i, obs, exp_v);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_sw();
      drive_instr(6'b101011, $urandom_range(0, 63), $urandom_range(0, 1));
      for (int n = exp_q.size(), i = 0; i < n; i++) begin
         @(negedge clk);
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL sw step %0d: got %h expected %h", i, obs, exp_v);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_rtype();
      logic [5:0] fn_tab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      for (int f = 0; f < 5; f++) begin
         drive_instr(6'b000000, fn_tab[f], $urandom_range(0, 1));
         for (int n = exp_q.size(), i = 0; i < n; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL rtype funct=%b step %0d: got %h expected %h", fn_tab[f], i, obs, exp_v);
            end
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_beq();
      for (int z = 1; z >= 0; z--) begin
         drive_instr(6'b000100, $urandom_range(0, 63), z[0]);
         for (int n = exp_q.size(), i = 0; i < n; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL beq zero=%0d step %0d: got %h expected %h", z, i, obs, exp_v);
            end
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_illegal();
      logic [5:0] op_tab[2] = '{6'b111111, 6'b000000};
      logic [5:0] fn_tab[2] = '{6'b000000, 6'b001000};
      for (int k = 0; k < 2; k++) begin
         drive_instr(op_tab[k], fn_tab[k], $urandom_range(0, 1));
         for (int n = exp_q.size(), i = 0; i < n; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL illegal op=%b funct=%b step %0d: got %h expected %h",
                        op_tab[k], fn_tab[k], i, obs, exp_v);
            end
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_reset_mid_op();
      drive_instr(6'b101011, 6'b000000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL midreset sw step %0d: got %h expected %h", i, obs, exp_v);
         end
         if (i < 3) begin
            @(posedge clk);
            #1;
         end
      end
      // Now in MEMWR with memWrite high; pull reset between edges.
      #2 resetN = 1'b0;
      #1;
      checks++;
      if (obs !== reset_vec()) begin
         errors++;
         $display("FAIL midreset async: got %h expected %h", obs, reset_vec());
      end
      @(posedge clk);
      #1;
      checks++;
      if (obs !== reset_vec()) begin
         errors++;
         $display("FAIL midreset held: got %h expected %h", obs, reset_vec());
      end
      resetN = 1'b1;
      drive_instr(6'b000010, $urandom_range(0, 63), $urandom_range(0, 1));
      for (int n = exp_q.size(), i = 0; i < n; i++) begin
         @(negedge clk);
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL jump step %0d: got %h expected %h", i, obs, exp_v);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_random();
      logic [5:0] bad_ops[5] = '{6'b111111, 6'b000001, 6'b000101, 6'b001100, 6'b100100};
      logic [5:0] good_fn[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      logic [5:0] op;
      logic [5:0] fn;
      for (int t = 0; t < 60; t++) begin
         fn = 6'($urandom_range(0, 63));
         case ($urandom_range(0, 7))
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: begin op = 6'b000000; fn = good_fn[$urandom_range(0, 4)]; end
            3: op = 6'b000100;
            4: op = 6'b001000;
            5: op = 6'b000010;
            6: op = bad_ops[$urandom_range(0, 4)];
            default: op = 6'b000000;
         endcase
         drive_instr(op, fn, $urandom_range(0, 1));
         for (int n = exp_q.size(), i = 0; i < n; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL random #%0d op=%b funct=%b step %0d: got %h expected %h",
                        t, op, fn, i, obs, exp_v);
            end
            @(posedge clk);
            #1;
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_sw();
      test_rtype();
      test_beq();
      test_illegal();
      test_reset_mid_op();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style main controller plus ALU decoder for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback cycles, driving the datapath mux selects and write enables. It also produces the 3-bit `aluControl` consumed directly by the `alu` stage. It sits upstream of the ALU and reads `op`/`funct` from the instruction register and `zero` from the ALU.

## Interface
- No parameters; all opcode, funct and state encodings are fixed.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `op`  in  6  instr[31:26] from the instruction register.
- `funct`  in  6  instr[5:0] from the instruction register.
- `zero`  in  1  ALU zero flag.
- `aluControl`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `aluSrcA`  out  1  0 = PC, 1 = register A.
- `aluSrcB`  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `pcSrc`  out  2  00 = aluOut (combinational), 01 = aluOut register, 10 = jump target.
- `iorD`  out  1  memory address select: 0 = PC, 1 = aluOut register.
- `irWrite`, `memWrite`, `regWrite`  out  1 each  write enables.
- `regDst`  out  1  write-register select: 0 = rt, 1 = rd.
- `memtoReg`  out  1  write-data select: 0 = aluOut register, 1 = memory data.
- `pcEn`  out  1  PC load enable, `pcWrite | (branch & zero)`.
- `instrDone`  out  1  high in the final cycle of every instruction.
- `illegalOp`  out  1  high in DECODE when op/funct is unsupported.
- `state`  out  4  current state, for debug.

## Operation
- Outputs are a decode of `state` only, except three signals: `pcEn` (uses `zero`), `aluControl` (uses `funct`), and DECODE's `illegalOp`/`instrDone` (use `op`/`funct`).
- Any output not listed for a state is 0.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Supported R-type funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- States, with asserted outputs and the next state:
  - FETCH(0): aluSrcB=01, aluOp=00, irWrite, pcWrite. Next: DECODE.
  - DECODE(1): aluSrcB=11, aluOp=00. Next by op: lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEXEC; j -> JUMP.
  - DECODE with an unsupported op, or R-type with an unsupported funct: illegalOp=1, instrDone=1. Next: FETCH; the instruction is executed as a no-op.
  - MEMADR(2): aluSrcA=1, aluSrcB=10, aluOp=00. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD(3): iorD=1. Next: MEMWB.
  - MEMWB(4): memtoReg=1, regWrite, instrDone. Next: FETCH.
  - MEMWR(5): iorD=1, memWrite, instrDone. Next: FETCH.
  - EXECUTE(6): aluSrcA=1, aluSrcB=00, aluOp=10. Next: ALUWB.
  - ALUWB(7): regDst=1, regWrite, instrDone. Next: FETCH.
  - BRANCH(8): aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, branch, instrDone. Next: FETCH.
  - ADDIEXEC(9): aluSrcA=1, aluSrcB=10, aluOp=00. Next: ADDIWB.
  - ADDIWB(10): regWrite, instrDone. Next: FETCH.
  - JUMP(11): pcSrc=10, pcWrite, instrDone. Next: FETCH.
  - Encodings 12-15: all enables 0. Next: FETCH.
- ALU decoder (internal `aluOp`):
  - aluOp 00 -> aluControl 010; aluOp 01 -> 110; aluOp 11 -> 010.
  - aluOp 10 -> decode funct: add 010, sub 110, and 000, or 001, slt 111; any other funct -> 010.
- `op` and `funct` are sampled every cycle. The datapath loads the IR only on `irWrite`, so both are stable from DECODE until the next FETCH.

## Timing
- Reset:
  - `resetN` low immediately forces `state`=FETCH(0), asynchronously.
  - While reset is asserted, `irWrite`, `memWrite`, `regWrite`, `pcEn`, `instrDone` and `illegalOp` are forced to 0.
  - Once reset deasserts, outputs follow FETCH decode (`aluControl`=010, `aluSrcB`=01). The first rising edge after release completes the first fetch.
- Reset asserted mid-instruction aborts it: no further register or memory writes occur, and the state returns to FETCH.
- Cycles per instruction, counted from the FETCH cycle inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- `pcEn` in BRANCH follows `zero` combinationally in the same cycle; there is no registered delay.
- `instrDone` is high for exactly one cycle per instruction; FETCH always follows it.

## Test plan
- Reset: hold `resetN`=0 for 3 cycles, then release with op=100011 -> state=0 and all enables 0 during reset. The next states are 1,2,3,4,0. `regWrite`=1 and `memtoReg`=1 only in state 4; `instrDone` is high only in state 4.
- sw (op=101011): states 0,1,2,5,0. `memWrite`=1 and `iorD`=1 only in state 5; `aluControl`=010 in state 2.
- R-type sweep, op=000000, each funct in turn: add/sub/and/or/slt -> `aluControl`=010/110/000/001/111 in state 6. `regWrite`=1 with `regDst`=1 in state 7.
- beq (op=000100):
  - zero=1 in state 8 -> `pcEn`=1, `pcSrc`=01, `aluControl`=110.
  - zero=0 -> `pcEn`=0.
  - Both cases then return to state 0.
- Illegal encodings:
  - op=111111 -> `illegalOp`=1 and `instrDone`=1 in state 1, then state 0; no write enable is ever high.
  - Repeat with op=000000, funct=001000 -> same response.
- Reset mid-operation: assert `resetN`=0 asynchronously between edges while in state 5 -> `memWrite` drops to 0 immediately and state=0. Then j (op=000010) runs states 0,1,11,0 with `pcEn`=1 and `pcSrc`=10 in state 11.
